// File: rtl/param_fetch_stage.sv
// Instruction-fetch stage with a direct-mapped instruction cache and a line-refill FSM.
// Delivers one instruction per cycle on hits and refills whole lines over a req/valid handshake.
module param_fetch_stage #(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 16,
  parameter int                LINE_WORDS = 4,
  parameter int                NUM_LINES  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          PC_src,
  input  logic [ADDR_W-1:0]             branch_target,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_valid,
  input  logic [INSTR_W*LINE_WORDS-1:0] mem_line,
  output logic [INSTR_W-1:0]            instr_fetch_out,
  output logic [ADDR_W-1:0]             instr_pc,
  output logic                          instr_valid,
  output logic                          hit_fetch_out
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = INSTR_W * LINE_WORDS;

  typedef enum logic {
    RUN,
    REFILL
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0]  pc;
  logic [NUM_LINES-1:0] line_valid;
  logic [TAG_W-1:0]   line_tag  [NUM_LINES];
  logic [LINE_W-1:0]  line_data [NUM_LINES];

  logic [OFF_W-1:0]   pc_off;
  logic [IDX_W-1:0]   pc_idx;
  logic [TAG_W-1:0]   pc_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic [INSTR_W-1:0] hit_word;
  logic               refill_done;

  assign pc_off   = pc[OFF_W-1:0];
  assign pc_idx   = pc[OFF_W +: IDX_W];
  assign pc_tag   = pc[ADDR_W-1 -: TAG_W];
  assign fill_idx = mem_addr[OFF_W +: IDX_W];
  assign fill_tag = mem_addr[ADDR_W-1 -: TAG_W];

  assign hit_fetch_out = (state == RUN) && line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag);
  assign refill_done   = (state == REFILL) && mem_valid;

  always_comb begin
    hit_word = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (pc_off == OFF_W'(k)) begin
        hit_word = line_data[pc_idx][k*INSTR_W +: INSTR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // A refill is only launched when neither redirect nor stall claims the cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (!PC_src && !stall && !hit_fetch_out) state_next = REFILL;
      REFILL:  if (mem_valid) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc              <= RESET_PC;
      line_valid      <= '0;
      mem_req         <= 1'b0;
      mem_addr        <= '0;
      instr_valid     <= 1'b0;
      instr_fetch_out <= '0;
      instr_pc        <= '0;
    end else if (state == RUN) begin
      if (PC_src) begin
        pc          <= branch_target;
        instr_valid <= 1'b0;
      end else if (!stall) begin
        if (hit_fetch_out) begin
          instr_fetch_out <= hit_word;
          instr_pc        <= pc;
          instr_valid     <= 1'b1;
          pc              <= pc + ADDR_W'(1);
        end else begin
          instr_valid <= 1'b0;
          mem_addr    <= {pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          mem_req     <= 1'b1;
        end
      end
    end else begin
      // A redirect mid-refill still lets the outstanding line land; the next lookup uses the new pc.
      if (PC_src) begin
        pc <= branch_target;
      end
      if (mem_valid) begin
        line_valid[fill_idx] <= 1'b1;
        mem_req              <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && refill_done) begin
      line_data[fill_idx] <= mem_line;
      line_tag[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_param_fetch_stage.sv
// Directed self-checking bench for param_fetch_stage: refill, stall, redirect,
// conflict, reset mid-refill and PC wrap (second instance with RESET_PC=0xFFFF).
module tb_param_fetch_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RESET_PC = 0
  logic        rst, stall, pc_src, mem_valid;
  logic [15:0] branch_target;
  logic [63:0] mem_line;
  logic        mem_req, instr_valid, hit;
  logic [15:0] mem_addr, instr_pc, instr;

  // Instance B: RESET_PC = 0xFFFF
  logic        rst_b, mem_valid_b;
  logic [63:0] mem_line_b;
  logic        mem_req_b, instr_valid_b, hit_b;
  logic [15:0] mem_addr_b, instr_pc_b, instr_b;

  int checks = 0;
  int failures = 0;

  param_fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PC_src(pc_src),
    .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_line(mem_line), .instr_fetch_out(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .hit_fetch_out(hit)
  );

  param_fetch_stage #(.RESET_PC(16'hFFFF)) dut_b (
    .clk(clk), .rst(rst_b), .stall(1'b0), .PC_src(1'b0),
    .branch_target(16'h0000), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
    .mem_valid(mem_valid_b), .mem_line(mem_line_b), .instr_fetch_out(instr_b),
    .instr_pc(instr_pc_b), .instr_valid(instr_valid_b), .hit_fetch_out(hit_b)
  );

  // Advance one clock and settle just after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFetch(input string tag, input logic [15:0] exp_pc, input logic [15:0] exp_instr);
    checkOutput({tag, ".valid"}, 32'(instr_valid), 32'd1);
    checkOutput({tag, ".pc"},    32'(instr_pc),    32'(exp_pc));
    checkOutput({tag, ".instr"}, 32'(instr),       32'(exp_instr));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = '0;
    mem_valid = 1'b0; mem_line = '0;
    rst_b = 1'b1; mem_valid_b = 1'b0; mem_line_b = '0;

    // Reset state
    applyStimulus();
    applyStimulus();
    checkOutput("rst.mem_req",     32'(mem_req),     32'd0);
    checkOutput("rst.mem_addr",    32'(mem_addr),    32'h0);
    checkOutput("rst.instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst.instr_pc",    32'(instr_pc),    32'h0);
    checkOutput("rst.instr",       32'(instr),       32'h0);

    // 1. Cold start: miss at 0, refill, stream four words
    rst = 1'b0;
    checkOutput("cold.hit0", 32'(hit), 32'd0);
    applyStimulus();
    checkOutput("cold.mem_req",  32'(mem_req),     32'd1);
    checkOutput("cold.mem_addr", 32'(mem_addr),    32'h0000);
    checkOutput("cold.ivalid",   32'(instr_valid), 32'd0);
    checkOutput("cold.hit_refill", 32'(hit),       32'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("cold.req_held", 32'(mem_req), 32'd1);
    mem_valid = 1'b1; mem_line = 64'h4444_3333_2222_1111;
    applyStimulus();
    mem_valid = 1'b0;
    checkOutput("cold.req_drop", 32'(mem_req), 32'd0);
    checkOutput("cold.hit_after", 32'(hit),    32'd1);
    applyStimulus(); checkFetch("cold.w0", 16'h0000, 16'h1111);
    applyStimulus(); checkFetch("cold.w1", 16'h0001, 16'h2222);
    applyStimulus(); checkFetch("cold.w2", 16'h0002, 16'h3333);
    applyStimulus(); checkFetch("cold.w3", 16'h0003, 16'h4444);
    applyStimulus();
    checkOutput("cold.miss4.req",    32'(mem_req),     32'd1);
    checkOutput("cold.miss4.addr",   32'(mem_addr),    32'h0004);
    checkOutput("cold.miss4.ivalid", 32'(instr_valid), 32'd0);

    // 4. Redirect during refill to 0x0002; line 1 still installed
    pc_src = 1'b1; branch_target = 16'h0002;
    applyStimulus();
    pc_src = 1'b0;
    checkOutput("rfr.addr_hold", 32'(mem_addr), 32'h0004);
    checkOutput("rfr.req_hold",  32'(mem_req),  32'd1);
    applyStimulus();
    checkOutput("rfr.addr_hold2", 32'(mem_addr),    32'h0004);
    checkOutput("rfr.ivalid",     32'(instr_valid), 32'd0);
    mem_valid = 1'b1; mem_line = 64'h8888_7777_6666_5555;
    applyStimulus();
    mem_valid = 1'b0;
    checkOutput("rfr.req_drop", 32'(mem_req), 32'd0);
    applyStimulus(); checkFetch("rfr.p2", 16'h0002, 16'h3333);
    applyStimulus(); checkFetch("rfr.p3", 16'h0003, 16'h4444);
    applyStimulus(); checkFetch("rfr.p4", 16'h0004, 16'h5555);
    checkOutput("rfr.no_req", 32'(mem_req), 32'd0);
    applyStimulus(); checkFetch("rfr.p5", 16'h0005, 16'h6666);

    // 2. Stall while streaming at pc 1
    pc_src = 1'b1; branch_target = 16'h0000;
    applyStimulus();
    pc_src = 1'b0;
    checkOutput("stl.redir_ivalid", 32'(instr_valid), 32'd0);
    applyStimulus(); checkFetch("stl.p0", 16'h0000, 16'h1111);
    applyStimulus(); checkFetch("stl.p1", 16'h0001, 16'h2222);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkFetch("stl.hold", 16'h0001, 16'h2222);
    end
    stall = 1'b0;
    applyStimulus(); checkFetch("stl.p2", 16'h0002, 16'h3333);

    // 3. Redirect on hit path at pc 3, then again with stall asserted
    pc_src = 1'b1; branch_target = 16'h0001;
    applyStimulus();
    pc_src = 1'b0;
    checkOutput("rdh.ivalid", 32'(instr_valid), 32'd0);
    applyStimulus(); checkFetch("rdh.p1", 16'h0001, 16'h2222);
    pc_src = 1'b1; stall = 1'b1; branch_target = 16'h0001;
    applyStimulus();
    pc_src = 1'b0; stall = 1'b0;
    checkOutput("rdhs.ivalid", 32'(instr_valid), 32'd0);
    applyStimulus(); checkFetch("rdhs.p1", 16'h0001, 16'h2222);

    // 5. Conflict: 0x0020 shares index 0 with 0x0000
    pc_src = 1'b1; branch_target = 16'h0020;
    applyStimulus();
    pc_src = 1'b0;
    checkOutput("cfl.hit20", 32'(hit), 32'd0);
    applyStimulus();
    checkOutput("cfl.req",  32'(mem_req),  32'd1);
    checkOutput("cfl.addr", 32'(mem_addr), 32'h0020);
    mem_valid = 1'b1; mem_line = 64'hDDDD_CCCC_BBBB_AAAA;
    applyStimulus();
    mem_valid = 1'b0;
    applyStimulus(); checkFetch("cfl.p20", 16'h0020, 16'hAAAA);
    pc_src = 1'b1; branch_target = 16'h0000;
    applyStimulus();
    pc_src = 1'b0;
    checkOutput("cfl.hit0", 32'(hit), 32'd0);
    applyStimulus();
    checkOutput("cfl.req0",  32'(mem_req),  32'd1);
    checkOutput("cfl.addr0", 32'(mem_addr), 32'h0000);

    // 6a. Reset mid-refill; a late mem_valid must not install a line
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("rmr.req",    32'(mem_req),     32'd0);
    checkOutput("rmr.ivalid", 32'(instr_valid), 32'd0);
    checkOutput("rmr.hit0",   32'(hit),         32'd0);
    mem_valid = 1'b1; mem_line = 64'h1234_1234_1234_1234;
    applyStimulus();
    mem_valid = 1'b0;
    checkOutput("rmr.miss_req",  32'(mem_req),  32'd1);
    checkOutput("rmr.miss_addr", 32'(mem_addr), 32'h0000);
    applyStimulus();
    checkOutput("rmr.still_req", 32'(mem_req),  32'd1);

    // 6b. Wrap on the RESET_PC=0xFFFF instance
    rst_b = 1'b0;
    checkOutput("wrp.hit", 32'(hit_b), 32'd0);
    applyStimulus();
    checkOutput("wrp.req",  32'(mem_req_b),  32'd1);
    checkOutput("wrp.addr", 32'(mem_addr_b), 32'hFFFC);
    mem_valid_b = 1'b1; mem_line_b = 64'h4000_3000_2000_1000;
    applyStimulus();
    mem_valid_b = 1'b0;
    applyStimulus();
    checkOutput("wrp.ivalid", 32'(instr_valid_b), 32'd1);
    checkOutput("wrp.pc",     32'(instr_pc_b),    32'hFFFF);
    checkOutput("wrp.instr",  32'(instr_b),       32'h4000);
    applyStimulus();
    checkOutput("wrp.req0",    32'(mem_req_b),     32'd1);
    checkOutput("wrp.addr0",   32'(mem_addr_b),    32'h0000);
    checkOutput("wrp.ivalid0", 32'(instr_valid_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
